// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes, datapath codes.
// Optional ADDI support is enabled by defining MIPS_CTRL_ADDI_EN.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned STATE_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'd35;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'd43;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'd8;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BEQ     = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_RESET   = 4'd15
    } state_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-unit <-> datapath bundle: IR opcode and memory ready in, control word and status out.
interface mips_multicycle_control_if;
    import mips_ctrl_pkg::*;

    logic [OPCODE_W-1:0] op_code;
    logic                mem_ready;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                MemtoReg;
    logic                IRWrite;
    logic                RegDst;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ALUOp;
    logic [1:0]          PCSource;
    logic                instr_done;
    logic                illegal_op;
    logic [CNT_W-1:0]    instr_count;
    logic [STATE_W-1:0]  state;

    modport master (
        input  op_code, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, illegal_op, instr_count, state
    );

    modport slave (
        output op_code, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, illegal_op, instr_count, state
    );

endinterface

// File: rtl/mips_ctrl_outdec.sv
// Combinational state (+mem_ready) to datapath control word decode.
// ADDI states decoded only when MIPS_CTRL_ADDI_EN is defined.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            // A store retires on the cycle memory accepts it
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control: state register, next-state logic, retired-instruction counter.
// Define MIPS_CTRL_ADDI_EN to add the ADDI execute/writeback path.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    mips_multicycle_control_if.master bus
);

    state_t           state_q;
    state_t           state_d;
    logic             illegal;
    ctrl_t            ctrl;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op_code)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.op_code == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDI_EX: state_d = S_ADDI_WB;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    // Retired count; illegal opcodes never raise instr_done so they are not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               count_q <= '0;
        else if (ctrl.instr_done) count_q <= count_q + CNT_W'(1);
    end

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.i_or_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.instr_done  = ctrl.instr_done;
    assign bus.illegal_op  = illegal;
    assign bus.instr_count = count_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: an instruction-level model expands each opcode
// into its expected state/control trace; a monitor compares the DUT every cycle.
module tb_mips_multicycle_control;

    logic clk;
    logic rst_n;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  st;
        logic [17:0] w;
        logic [15:0] c;
    } exp_t;

    typedef struct {
        int st;
        int mode;   // 0: mem_ready low, 1: mem_ready high, 2: random (ignored by DUT)
    } step_t;

    exp_t        sb[$];
    step_t       steps[$];
    int          compared;
    int          mismatched;
    logic [15:0] model_cnt;

    function automatic bit legal(input logic [5:0] op);
        bit r;
        r = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) || (op == 6'd2);
`ifdef MIPS_CTRL_ADDI_EN
        r = r || (op == 6'd8);
`endif
        return r;
    endfunction

    // Expected control word per state, straight from the control table
    function automatic logic [17:0] exp_word(input int st, input logic rdy, input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, sa, done, ill;
        logic [1:0] sb_, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, sa, done, ill} = '0;
        sb_ = 2'd0; aop = 2'd0; pcs = 2'd0;
        case (st)
            0:  begin mrd = 1; sb_ = 2'd1; irw = rdy; pcw = rdy; end
            1:  begin sb_ = 2'd3; ill = !legal(op); end
            2:  begin sa = 1; sb_ = 2'd2; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mwr = 1; iord = 1; done = rdy; end
            6:  begin sa = 1; aop = 2'd2; end
            7:  begin rw = 1; rdst = 1; done = 1; end
            8:  begin sa = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; done = 1; end
            9:  begin pcw = 1; pcs = 2'd2; done = 1; end
`ifdef MIPS_CTRL_ADDI_EN
            10: begin sa = 1; sb_ = 2'd2; end
            11: begin rw = 1; done = 1; end
`endif
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, sa, sb_, aop, pcs, done, ill};
    endfunction

    function automatic step_t mk(input int st, input int mode);
        step_t s;
        s.st = st;
        s.mode = mode;
        return s;
    endfunction

    // Expand one instruction into its state walk, with fetch and memory stall counts
    task automatic plan(input logic [5:0] op, input int fs, input int ms);
        steps.delete();
        for (int i = 0; i < fs; i++) steps.push_back(mk(0, 0));
        steps.push_back(mk(0, 1));
        steps.push_back(mk(1, 2));
        case (op)
            6'd35: begin
                steps.push_back(mk(2, 2));
                for (int i = 0; i < ms; i++) steps.push_back(mk(3, 0));
                steps.push_back(mk(3, 1));
                steps.push_back(mk(4, 2));
            end
            6'd43: begin
                steps.push_back(mk(2, 2));
                for (int i = 0; i < ms; i++) steps.push_back(mk(5, 0));
                steps.push_back(mk(5, 1));
            end
            6'd0: begin
                steps.push_back(mk(6, 2));
                steps.push_back(mk(7, 2));
            end
            6'd4: steps.push_back(mk(8, 2));
            6'd2: steps.push_back(mk(9, 2));
`ifdef MIPS_CTRL_ADDI_EN
            6'd8: begin
                steps.push_back(mk(10, 2));
                steps.push_back(mk(11, 2));
            end
`endif
            default: ;
        endcase
    endtask

    function automatic exp_t mkexp(input logic [3:0] st, input logic [17:0] w, input logic [15:0] c);
        exp_t e;
        e.st = st;
        e.w = w;
        e.c = c;
        return e;
    endfunction

    // Drive up to 'limit' planned cycles; optionally preload the counter to 0xFFFF first
    task automatic drive(input logic [5:0] op, input int limit, input bit preload);
        logic        rdy;
        logic [17:0] w;
        for (int i = 0; i < steps.size() && i < limit; i++) begin
            @(posedge clk);
            #1;
            if (preload && i == 0) begin
                force dut.count_q = 16'hFFFF;
                #0;
                release dut.count_q;
                model_cnt = 16'hFFFF;
            end
            rdy = (steps[i].mode == 2) ? 1'($urandom_range(0, 1)) : 1'(steps[i].mode);
            bus.mem_ready = rdy;
            bus.op_code = (steps[i].st == 0) ? 6'($urandom_range(0, 63)) : op;
            w = exp_word(steps[i].st, rdy, op);
            sb.push_back(mkexp(4'(steps[i].st), w, model_cnt));
            if (w[1]) model_cnt = model_cnt + 16'd1;
        end
    endtask

    task automatic run(input logic [5:0] op, input int fs, input int ms);
        plan(op, fs, ms);
        drive(op, 1000, 1'b0);
    endtask

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] req, input logic [3:0] st);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s (state exp %0d): got 0x%0h, expected 0x%0h", name, st, act, req);
        end
    endtask

    function automatic logic [17:0] act_word();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg,
                bus.IRWrite, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.PCSource, bus.instr_done, bus.illegal_op};
    endfunction

    // Monitor: one expected record per cycle, checked mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("state", 18'(bus.state), 18'(e.st), e.st);
                check("ctrl", act_word(), e.w, e.st);
                check("instr_count", 18'(bus.instr_count), 18'(e.c), e.st);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ops[7];
        int          k;
        logic [5:0]  op;
        compared = 0;
        mismatched = 0;
        model_cnt = 16'd0;
        ops = '{0, 35, 43, 4, 2, 8, 63};
        rst_n = 1'b0;
        bus.op_code = 6'd0;
        bus.mem_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 18'(bus.state), 18'hF, 4'hF);
        check("reset_ctrl", act_word(), 18'd0, 4'hF);
        check("reset_count", 18'(bus.instr_count), 18'd0, 4'hF);

        rst_n = 1'b1;
        sb.push_back(mkexp(4'hF, 18'd0, model_cnt));

        run(6'd0, 0, 0);
        run(6'd35, 1, 3);
        run(6'd43, 0, 2);
        run(6'd4, 2, 0);
        run(6'd2, 0, 0);
        run(6'd63, 0, 0);
        run(6'd8, 1, 0);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 7);
            op = (k == 7) ? 6'($urandom_range(0, 63)) : 6'(ops[k]);
            run(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Counter wrap: preload 0xFFFF, then retire one jump
        plan(6'd2, 0, 0);
        drive(6'd2, 1000, 1'b1);

        // Abort a load while it is stalled in S_MEMRD
        plan(6'd35, 0, 3);
        drive(6'd35, 5, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_cnt = 16'd0;
        sb.push_back(mkexp(4'hF, 18'd0, model_cnt));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.push_back(mkexp(4'hF, 18'd0, model_cnt));
        run(6'd0, 0, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Multi-cycle MIPS main control unit. It is the sequential successor to the single-cycle opcode decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives datapath control per state.
- Supports a variable-latency memory handshake, a retired-instruction counter and illegal-opcode reporting.
- Sits between the instruction register and the shared-memory multi-cycle datapath.

Parameters:
OPCODE_W, 6, opcode field width
CNT_W, 16, width of retired-instruction counter
OP_RTYPE, 0, R-type opcode
OP_LW, 35, load word opcode
OP_SW, 43, store word opcode
OP_BEQ, 4, branch-equal opcode
OP_J, 2, jump opcode
OP_ADDI, 8, add-immediate opcode (used only with macro)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_code  in  OPCODE_W  opcode from instruction register (valid from S_DECODE on)
mem_ready  in  1  memory completes access this cycle
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write if ALU zero
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR
IRWrite  out  1  load instruction register
RegDst  out  1  write register: 0=rt, 1=rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=4, 10=signext, 11=signext<<2
ALUOp  out  2  00=add, 01=sub, 10=funct
PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
instr_done  out  1  one-cycle pulse on final cycle of a retired instruction
illegal_op  out  1  one-cycle pulse in S_DECODE on an unsupported opcode
instr_count  out  CNT_W  retired-instruction count
state  out  4  current state, for debug

Behaviour:
- Reset (async, rst_n=0): state=S_RESET(0xF), instr_count=0. All control outputs are 0, including instr_done and illegal_op.
- First rising edge with rst_n=1: S_RESET->S_FETCH.
- All control outputs are a combinational decode of state (plus mem_ready where noted). Unlisted outputs are 0 in every state.
- S_FETCH(0): MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in S_FETCH while mem_ready=0; goes to S_DECODE when mem_ready=1.
- S_DECODE(1): ALUSrcB=11, ALUOp=00. Next state by op_code:
  - LW/SW -> S_MEMADR
  - RTYPE -> S_EXEC
  - BEQ -> S_BEQ
  - J -> S_JUMP
  - otherwise: illegal_op=1, next S_FETCH
- S_MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> S_MEMRD, SW -> S_MEMWR. op_code is sampled here and must be held stable by the IR.
- S_MEMRD(3): MemRead=1, IorD=1. Holds while mem_ready=0, then -> S_MEMWB.
- S_MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next S_FETCH.
- S_MEMWR(5): MemWrite=1, IorD=1, instr_done=mem_ready. Holds while mem_ready=0, then -> S_FETCH.
- S_EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next S_RWB.
- S_RWB(7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next S_FETCH.
- S_BEQ(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next S_FETCH.
- S_JUMP(9): PCWrite=1, PCSource=10, instr_done=1. Next S_FETCH.
- Any undefined state encoding -> S_FETCH on the next edge, with outputs 0.
- instr_count increments by 1 on each clk edge where instr_done=1. It wraps from 2^CNT_W-1 to 0. Illegal opcodes are not counted.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction returns to S_RESET immediately. Any memory access in progress is abandoned and the counter clears.

Optional Feature:
MIPS_CTRL_ADDI_EN
- Defined: adds S_ADDI_EX(10) and S_ADDI_WB(11).
  - S_DECODE routes OP_ADDI -> S_ADDI_EX.
  - S_ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - S_ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1, next S_FETCH.
- Undefined: OP_ADDI is illegal (illegal_op pulse, not counted); encodings 10 and 11 are unused.

Decomposition:
- Package mips_ctrl_pkg holds the state encodings (S_*), the ALUOp/ALUSrcB/PCSource code constants and the default opcode values.
- One sub-module, mips_ctrl_outdec: purely combinational state(+mem_ready) -> control-word decode. The top module keeps the state register, next-state logic and counter.

Test Plan:
- Reset then mem_ready=1 constant, op_code=0: state sequence 0xF,0,1,6,7,0. The S_RWB cycle shows RegWrite=1, RegDst=1, instr_done=1. instr_count=1.
- op_code=35 with mem_ready=0 for 3 cycles in S_MEMRD: S_MEMRD held for 4 cycles with MemRead=1, IorD=1. LW retires in 5 states excluding stalls (FETCH, DECODE, MEMADR, MEMRD, MEMWB). instr_count advances by 1.
- op_code=43, mem_ready low 2 cycles in S_MEMWR: MemWrite=1 for 3 cycles. instr_done high only on the mem_ready=1 cycle.
- op_code=4 then op_code=2: S_BEQ shows PCWriteCond=1, ALUOp=01, PCSource=01. S_JUMP shows PCWrite=1, PCSource=10. Count +2.
- op_code=63: illegal_op pulses 1 cycle in S_DECODE, next S_FETCH, count unchanged. op_code=8 behaves the same unless MIPS_CTRL_ADDI_EN is defined, in which case the sequence is 1,10,11,0 and count +1.
- Preload via 65535 R-types (or force counter 0xFFFF) then one more instruction: instr_count=0. Then rst_n=0 mid S_MEMRD: outputs 0 and state=0xF immediately.
